// File: rtl/bip_instruction_fetch_if.sv
// Bus between the BIP fetch/issue front end, program ROM and instruction decoder.
// master = fetch unit; slave = surrounding datapath (ROM, decoder, control).
interface bip_instruction_fetch_if #(
   parameter int unsigned PC_W  = 11,
   parameter int unsigned CNT_W = 16
);
   logic             start;
   logic             stall;
   logic [PC_W-1:0]  prog_addr;
   logic [15:0]      instr_data;
   logic [4:0]       opcode;
   logic [10:0]      operand;
   logic             op_valid;
   logic             halted;
   logic             busy;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  start, stall, instr_data,
      output prog_addr, opcode, operand, op_valid, halted, busy, instr_count
   );

   modport slave (
      output start, stall, instr_data,
      input  prog_addr, opcode, operand, op_valid, halted, busy, instr_count
   );
endinterface

// File: rtl/bip_instruction_fetch.sv
// BIP fetch/issue front end: walks program ROM with the PC, splits each word into
// opcode/operand and issues it to the decoder as a one-cycle pulse; stops on HLT.
module bip_instruction_fetch #(
   parameter int unsigned PC_W  = 11,
   parameter int unsigned CNT_W = 16
) (
   input logic                     clk,
   input logic                     reset,
   bip_instruction_fetch_if.master bus
);
   localparam int unsigned ST_W  = 2;
   localparam int unsigned OP_W  = 5;
   localparam int unsigned ARG_W = 11;

   localparam logic [ST_W-1:0] S_IDLE  = 2'd0;
   localparam logic [ST_W-1:0] S_FETCH = 2'd1;
   localparam logic [ST_W-1:0] S_ISSUE = 2'd2;
   localparam logic [ST_W-1:0] S_HALT  = 2'd3;

   localparam logic [OP_W-1:0]  OP_HLT  = 5'b00000;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [ST_W-1:0]  state,    state_nx;
   logic [PC_W-1:0]  pc,       pc_nx;
   logic [OP_W-1:0]  opcode,   opcode_nx;
   logic [ARG_W-1:0] operand,  operand_nx;
   logic             op_valid, op_valid_nx;
   logic             halted,   halted_nx;
   logic             busy,     busy_nx;
   logic [CNT_W-1:0] count,    count_nx;

   logic [OP_W-1:0]  word_op;
   logic [ARG_W-1:0] word_arg;

   assign word_op  = bus.instr_data[15:11];
   assign word_arg = bus.instr_data[10:0];

   // State and output registers; prog_addr is the PC register itself
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         pc       <= '0;
         opcode   <= '0;
         operand  <= '0;
         op_valid <= 1'b0;
         halted   <= 1'b0;
         busy     <= 1'b0;
         count    <= '0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         opcode   <= opcode_nx;
         operand  <= operand_nx;
         op_valid <= op_valid_nx;
         halted   <= halted_nx;
         busy     <= busy_nx;
         count    <= count_nx;
      end
   end

   // Next state and next register values
   always_comb begin
      state_nx    = state;
      pc_nx       = pc;
      opcode_nx   = opcode;
      operand_nx  = operand;
      op_valid_nx = 1'b0;
      count_nx    = count;

      case (state)
         S_IDLE, S_HALT: begin
            if (bus.start) begin
               state_nx = S_FETCH;
               pc_nx    = '0;
               count_nx = '0;
            end
         end
         S_FETCH: begin
            if (!bus.stall) state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            operand_nx = word_arg;
            if (word_op == OP_HLT) begin
               // HLT is reported through halted only; PC and count stay put
               state_nx  = S_HALT;
               opcode_nx = OP_HLT;
            end else begin
               state_nx    = S_FETCH;
               opcode_nx   = word_op;
               op_valid_nx = 1'b1;
               pc_nx       = pc + PC_W'(1);
               if (count != CNT_MAX) count_nx = count + CNT_W'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase

      halted_nx = (state_nx == S_HALT);
      busy_nx   = (state_nx == S_FETCH) || (state_nx == S_ISSUE);
   end

   assign bus.prog_addr   = pc;
   assign bus.opcode      = opcode;
   assign bus.operand     = operand;
   assign bus.op_valid    = op_valid;
   assign bus.halted      = halted;
   assign bus.busy        = busy;
   assign bus.instr_count = count;
endmodule

// File: tb/tb_bip_instruction_fetch.sv
// Scoreboard bench for bip_instruction_fetch: a ROM-walking reference model
// predicts the issue stream; a monitor pops and compares on every op_valid.
module tb_bip_instruction_fetch;
   logic clk = 1'b0;
   logic reset_a, reset_b;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bip_instruction_fetch_if #(.PC_W(11), .CNT_W(16)) ia ();
   bip_instruction_fetch_if #(.PC_W(2),  .CNT_W(2))  ib ();

   bip_instruction_fetch #(.PC_W(11), .CNT_W(16)) dut_a (.clk(clk), .reset(reset_a), .bus(ia));
   bip_instruction_fetch #(.PC_W(2),  .CNT_W(2))  dut_b (.clk(clk), .reset(reset_b), .bus(ib));

   logic [15:0] rom_a [2048];
   logic [15:0] rom_b [4];
   always @(posedge clk) ia.instr_data <= rom_a[ia.prog_addr];
   always @(posedge clk) ib.instr_data <= rom_b[ib.prog_addr];

   logic stall_en = 1'b0;
   logic stall_dir = 1'b0;
   logic stall_rnd = 1'b0;
   always @(negedge clk) stall_rnd <= ($urandom_range(0, 2) == 0);
   assign ia.stall = stall_en ? stall_rnd : stall_dir;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int op; int arg; int cnt; } exp_t;
   exp_t exp_q[$];
   int   exp_final;
   int   exp_hlt_arg;

   function automatic void build_expected_a();
      int pc = 0;
      int cnt = 0;
      logic [15:0] w;
      exp_t e;
      exp_q.delete();
      exp_hlt_arg = -1;
      for (int s = 0; s < 4096; s++) begin
         w = rom_a[pc];
         if (w[15:11] == 5'd0) begin
            exp_hlt_arg = int'(w[10:0]);
            break;
         end
         if (cnt < 65535) cnt++;
         e.op = int'(w[15:11]); e.arg = int'(w[10:0]); e.cnt = cnt;
         exp_q.push_back(e);
         pc = (pc + 1) % 2048;
      end
      exp_final = cnt;
   endfunction

   // ---------------- monitor A ----------------
   int pulse_cyc[$];
   int last_pulse = -100;
   always @(negedge clk) begin
      exp_t e;
      if (!reset_a && ia.op_valid) begin
         pulse_cyc.push_back(cyc);
         check("issue_gap_ge2", longint'(cyc - last_pulse >= 2), 1);
         last_pulse = cyc;
         if (exp_q.size() == 0) begin
            check("unexpected_issue", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("issue_opcode",  ia.opcode,      e.op);
            check("issue_operand", ia.operand,     e.arg);
            check("issue_count",   ia.instr_count, e.cnt);
         end
      end
   end

   // ---------------- monitor B (PC_W=2, CNT_W=2, ROM all LDI 0) ----------------
   int nb = 0;
   always @(negedge clk) begin
      if (!reset_b && ib.op_valid) begin
         nb++;
         check("b_prog_addr_wrap", ib.prog_addr,   nb % 4);
         check("b_count_sat",      ib.instr_count, (nb < 3) ? nb : 3);
         check("b_opcode",         ib.opcode,      3);
         check("b_operand",        ib.operand,     0);
         check("b_not_halted",     ib.halted,      0);
      end
   end

   logic done_b = 1'b0;
   initial begin
      reset_b = 1'b1; ib.start = 1'b0; ib.stall = 1'b0;
      for (int i = 0; i < 4; i++) rom_b[i] = 16'h1800;
      repeat (3) @(negedge clk);
      reset_b = 1'b0;
      ib.start = 1'b1;
      @(negedge clk) ib.start = 1'b0;
      for (int i = 0; i < 200 && nb < 10; i++) @(negedge clk);
      check("b_issue_progress", longint'(nb >= 10), 1);
      reset_b = 1'b1;
      done_b = 1'b1;
   end

   // ---------------- helpers for DUT A ----------------
   task automatic pulse_start_a();
      ia.start = 1'b1;
      @(negedge clk) ia.start = 1'b0;
   endtask

   task automatic wait_halt_a(input int bound);
      int i;
      for (i = 0; i < bound && !ia.halted; i++) @(negedge clk);
      if (!ia.halted) check("halt_timeout", 0, 1);
   endtask

   task automatic wait_pulse_a(input int bound);
      int i;
      @(negedge clk);
      for (i = 0; i < bound && !ia.op_valid; i++) @(negedge clk);
      if (!ia.op_valid) check("pulse_timeout", 0, 1);
   endtask

   task automatic check_halt_state_a(input string tag);
      check({tag, "_queue_drained"}, exp_q.size(), 0);
      check({tag, "_halted"},        ia.halted,      1);
      check({tag, "_busy"},          ia.busy,        0);
      check({tag, "_count"},         ia.instr_count, exp_final);
      check({tag, "_hlt_opcode"},    ia.opcode,      0);
      check({tag, "_hlt_operand"},   ia.operand,     exp_hlt_arg);
   endtask

   task automatic check_pulse_spacing(input string tag, input int n);
      check({tag, "_pulses"}, pulse_cyc.size(), n);
      for (int i = 1; i < pulse_cyc.size(); i++)
         check({tag, "_spacing"}, pulse_cyc[i] - pulse_cyc[i-1], 2);
   endtask

   task automatic load_prog2();
      for (int i = 0; i < 2048; i++) rom_a[i] = 16'h0000;
      rom_a[0] = 16'h0805; rom_a[1] = 16'h1003; rom_a[2] = 16'h2001; rom_a[3] = 16'h0000;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_prog_addr"}, ia.prog_addr,   0);
      check({tag, "_opcode"},    ia.opcode,      0);
      check({tag, "_operand"},   ia.operand,     0);
      check({tag, "_op_valid"},  ia.op_valid,    0);
      check({tag, "_halted"},    ia.halted,      0);
      check({tag, "_busy"},      ia.busy,        0);
      check({tag, "_count"},     ia.instr_count, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int len;
      reset_a = 1'b1; ia.start = 1'b0;
      load_prog2();
      repeat (3) @(negedge clk);
      check_reset_state("por");
      reset_a = 1'b0;

      // Basic program: three issues two cycles apart, then HLT
      build_expected_a();
      pulse_cyc.delete();
      pulse_start_a();
      wait_halt_a(100);
      check_halt_state_a("prog2");
      check_pulse_spacing("prog2", 3);

      // Stall held four cycles in FETCH at PC=1
      build_expected_a();
      pulse_start_a();
      wait_pulse_a(20);
      stall_dir = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_prog_addr", ia.prog_addr,   1);
         check("stall_no_issue",  ia.op_valid,    0);
         check("stall_count",     ia.instr_count, 1);
         check("stall_busy",      ia.busy,        1);
      end
      stall_dir = 1'b0;
      @(negedge clk) check("stall_resume_gap", ia.op_valid, 0);
      @(negedge clk) check("stall_resume_issue", ia.op_valid, 1);
      wait_halt_a(100);
      check_halt_state_a("stall");

      // start while busy is ignored; start in HALT restarts cleanly
      build_expected_a();
      pulse_start_a();
      wait_pulse_a(20);
      pulse_start_a();
      wait_halt_a(100);
      check_halt_state_a("start_busy");
      build_expected_a();
      pulse_cyc.delete();
      pulse_start_a();
      check("restart_halted",    ia.halted,      0);
      check("restart_prog_addr", ia.prog_addr,   0);
      check("restart_count",     ia.instr_count, 0);
      check("restart_busy",      ia.busy,        1);
      check("restart_hold_opc",  ia.opcode,      0);
      wait_halt_a(100);
      check_halt_state_a("rerun");
      check_pulse_spacing("rerun", 3);

      // Random programs with random stalls
      stall_en = 1'b1;
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(0, 60);
         for (int i = 0; i < len; i++) rom_a[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
         rom_a[len] = {5'd0, 11'($urandom)};
         build_expected_a();
         pulse_start_a();
         wait_halt_a(1000);
         check_halt_state_a("random");
      end
      stall_en = 1'b0;

      // Reset held three cycles starting mid-ISSUE
      load_prog2();
      build_expected_a();
      pulse_start_a();
      wait_pulse_a(20);
      @(posedge clk);
      #1 reset_a = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("rst_mid_issue");
      exp_q.delete();
      // Reset wins over a simultaneous start
      ia.start = 1'b1;
      @(negedge clk);
      ia.start = 1'b0;
      reset_a = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_state("rst_over_start");

      for (int i = 0; i < 500 && !done_b; i++) @(negedge clk);
      check("b_done", done_b, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
